// File: rtl/spi_pkg.sv
// Shared SPI link definitions: receiver FSM encoding, idle clock level and the
// clock divide used by the transmitter side of the link.
package spi_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } spi_state_e;

   localparam logic SPI_CLK_IDLE   = 1'b1;
   localparam int   SPI_DATA_WIDTH = 8;
   localparam int   SPI_CLK_DIV    = 5;

endpackage : spi_pkg

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous level with a registered copy of
// the synchronized level and a registered rising-edge strobe aligned with it.
module sync_edge_detect #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d_in,
   output logic level_out,
   output logic rise_out
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;
   logic              level_q;
   logic              level_d;
   logic              rise_q;
   logic              rise_d;

   always_comb begin
      sync_d  = {sync_q[STAGES-2:0], d_in};
      level_d = sync_q[STAGES-1];
      // level_q holds the previous synchronized value, so this is a clean 0->1 detect.
      rise_d  = sync_q[STAGES-1] & ~level_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q  <= {STAGES{RESET_VAL}};
         level_q <= RESET_VAL;
         rise_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         level_q <= level_d;
         rise_q  <= rise_d;
      end
   end

   assign level_out = level_q;
   assign rise_out  = rise_q;

endmodule : sync_edge_detect

// File: rtl/spi_receiver.sv
// Oversampling SPI byte receiver (mode with idle-high clock, rising-edge sample,
// MSB first) presenting completed frames on a single-entry valid/ready buffer.
module spi_receiver
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH     = SPI_DATA_WIDTH,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  spi_clock,
   input  logic                  spi_data,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   input  logic                  data_ready,
   output logic                  busy,
   output logic                  overrun,
   output logic                  frame_error
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
   localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES - 1);

   logic sclk_rise;
   logic sclk_level;
   logic sdata;
   logic sdata_rise_unused;

   sync_edge_detect #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (SPI_CLK_IDLE)
   ) u_sclk_sync (
      .clk       (clk),
      .reset     (reset),
      .d_in      (spi_clock),
      .level_out (sclk_level),
      .rise_out  (sclk_rise)
   );

   // Same depth as the clock path so the data sample lines up with sclk_rise.
   sync_edge_detect #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (1'b0)
   ) u_sdata_sync (
      .clk       (clk),
      .reset     (reset),
      .d_in      (spi_data),
      .level_out (sdata),
      .rise_out  (sdata_rise_unused)
   );

   spi_state_e            state_q, state_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [TMO_W-1:0]      tmo_q, tmo_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  overrun_q, overrun_d;
   logic                  ferr_q, ferr_d;

   logic                  consume;
   logic                  complete;
   logic [DATA_WIDTH-1:0] shift_next;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      tmo_d      = tmo_q;
      shift_d    = shift_q;
      data_d     = data_q;
      valid_d    = valid_q;
      overrun_d  = 1'b0;
      ferr_d     = 1'b0;
      complete   = 1'b0;
      consume    = valid_q & data_ready;
      shift_next = {shift_q[DATA_WIDTH-2:0], sdata};

      if (consume) begin
         valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            tmo_d = '0;
            if (sclk_rise) begin
               shift_d   = shift_next;
               bit_cnt_d = CNT_W'(1);
               state_d   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            // An edge always beats the timeout in the same cycle.
            if (sclk_rise) begin
               shift_d = shift_next;
               tmo_d   = '0;
               if (bit_cnt_q == LAST_BIT) begin
                  complete  = 1'b1;
                  bit_cnt_d = '0;
                  state_d   = ST_IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end else if (tmo_q == TMO_MAX) begin
               ferr_d    = 1'b1;
               shift_d   = '0;
               bit_cnt_d = '0;
               tmo_d     = '0;
               state_d   = ST_IDLE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         default: begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            tmo_d     = '0;
         end
      endcase

      // A buffer being drained this cycle counts as free for the new byte.
      if (complete) begin
         if (!valid_q || consume) begin
            data_d  = shift_next;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         tmo_q     <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         tmo_q     <= tmo_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         ferr_q    <= ferr_d;
      end
   end

   assign data_out    = data_q;
   assign data_valid  = valid_q;
   assign busy        = (state_q == ST_SHIFT);
   assign overrun     = overrun_q;
   assign frame_error = ferr_q;

endmodule : spi_receiver

// File: tb/tb_spi_receiver.sv
// Self-checking bench for spi_receiver: directed scenarios plus randomized
// frames scored against a byte-level queue model.
module tb_spi_receiver;
   import spi_pkg::*;

   localparam int W   = 8;
   localparam int SS  = 2;
   localparam int TMO = 64;

   logic         clk = 1'b0;
   logic         reset;
   logic         spi_clock;
   logic         spi_data;
   logic         data_ready;
   logic [W-1:0] data_out;
   logic         data_valid;
   logic         busy;
   logic         overrun;
   logic         frame_error;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];
   int valid_cycles   = 0;
   int overrun_cycles = 0;
   int ferr_cycles    = 0;
   int busy_cycles    = 0;

   spi_receiver #(
      .DATA_WIDTH     (W),
      .SYNC_STAGES    (SS),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .spi_clock   (spi_clock),
      .spi_data    (spi_data),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .busy        (busy),
      .overrun     (overrun),
      .frame_error (frame_error)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every accepted byte must match the head of the expected queue.
   always @(negedge clk) begin
      if (!reset) begin
         if (data_valid)  valid_cycles++;
         if (overrun)     overrun_cycles++;
         if (frame_error) ferr_cycles++;
         if (busy)        busy_cycles++;
         if (data_valid && data_ready) begin
            if (exp_q.size() == 0) check_eq("spurious_byte_queue", exp_q.size(), 1);
            else                   check_eq("rx_byte", data_out, exp_q.pop_front());
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [W-1:0] v, input int nbits, input int half);
      for (int i = 0; i < nbits; i++) begin
         spi_clock = 1'b0;
         spi_data  = v[W-1-i];
         wait_clk(half);
         spi_clock = 1'b1;
         wait_clk(half);
      end
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || data_valid) && n < 400) begin
         wait_clk(1);
         n++;
      end
      check_eq(tag, exp_q.size(), 0);
   endtask

   initial begin
      #20000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int v0, o0, f0, b0;
      logic [W-1:0] byte_v;
      logic [W-1:0] pat;
      int half, gap;

      reset      = 1'b1;
      spi_clock  = SPI_CLK_IDLE;
      spi_data   = 1'b0;
      data_ready = 1'b0;
      wait_clk(3);
      check_eq("reset_data_out", data_out, 0);
      check_eq("reset_valid", data_valid, 0);
      check_eq("reset_busy", busy, 0);
      check_eq("reset_overrun", overrun, 0);
      check_eq("reset_ferr", frame_error, 0);
      reset = 1'b0;
      wait_clk(2);

      // Single byte, consumer always ready.
      data_ready = 1'b1;
      v0 = valid_cycles; o0 = overrun_cycles; f0 = ferr_cycles;
      exp_q.push_back(8'hA5);
      send_bits(8'hA5, W, SPI_CLK_DIV);
      wait_drain("drain_a5");
      check_eq("a5_data_out", data_out, 8'hA5);
      check_eq("a5_valid_width", valid_cycles - v0, 1);
      check_eq("a5_overrun", overrun_cycles - o0, 0);
      check_eq("a5_ferr", ferr_cycles - f0, 0);

      // Back-to-back with consumer stalled: second byte overruns.
      data_ready = 1'b0;
      o0 = overrun_cycles;
      send_bits(8'h3C, W, SPI_CLK_DIV);
      send_bits(8'hFF, W, SPI_CLK_DIV);
      wait_clk(10);
      check_eq("ovr_valid_held", data_valid, 1);
      check_eq("ovr_data_out", data_out, 8'h3C);
      check_eq("ovr_pulse_count", overrun_cycles - o0, 1);
      exp_q.push_back(8'h3C);
      data_ready = 1'b1;
      wait_drain("drain_3c");
      check_eq("ovr_after_drain", data_out, 8'h3C);

      // Partial frame followed by a stuck-high clock.
      f0 = ferr_cycles;
      pat = 8'hE0;
      send_bits(pat, 3, SPI_CLK_DIV);
      wait_clk(30);
      check_eq("tmo_busy_mid", busy, 1);
      check_eq("tmo_no_early_ferr", ferr_cycles - f0, 0);
      wait_clk(70);
      check_eq("tmo_ferr_pulse", ferr_cycles - f0, 1);
      check_eq("tmo_busy_drop", busy, 0);
      exp_q.push_back(8'h81);
      send_bits(8'h81, W, SPI_CLK_DIV);
      wait_drain("drain_81");
      check_eq("tmo_next_byte", data_out, 8'h81);

      // Reset in the middle of a frame.
      send_bits(8'h55, 4, SPI_CLK_DIV);
      reset = 1'b1;
      #1;
      check_eq("midrst_data_out", data_out, 0);
      check_eq("midrst_valid", data_valid, 0);
      check_eq("midrst_busy", busy, 0);
      check_eq("midrst_overrun", overrun, 0);
      check_eq("midrst_ferr", frame_error, 0);
      wait_clk(3);
      reset = 1'b0;
      wait_clk(3);
      exp_q.push_back(8'hC3);
      send_bits(8'hC3, W, SPI_CLK_DIV);
      wait_drain("drain_c3");
      check_eq("midrst_next_byte", data_out, 8'hC3);

      // Consume in exactly the completion cycle: the completion edge is the
      // (SYNC_STAGES+2)-th clk edge counting the one that samples the last rise.
      data_ready = 1'b0;
      send_bits(8'h12, W, SPI_CLK_DIV);
      wait_clk(10);
      check_eq("same_cyc_held", data_out, 8'h12);
      o0 = overrun_cycles;
      exp_q.push_back(8'h12);
      exp_q.push_back(8'h34);
      byte_v = 8'h34;
      send_bits(byte_v, W - 1, SPI_CLK_DIV);
      spi_clock = 1'b0;
      spi_data  = byte_v[0];
      wait_clk(SPI_CLK_DIV);
      spi_clock = 1'b1;
      wait_clk(SS + 1);
      data_ready = 1'b1;
      wait_clk(1);
      data_ready = 1'b0;
      check_eq("same_cyc_data", data_out, 8'h34);
      check_eq("same_cyc_valid", data_valid, 1);
      check_eq("same_cyc_overrun", overrun_cycles - o0, 0);
      wait_clk(SPI_CLK_DIV);
      data_ready = 1'b1;
      wait_drain("drain_34");

      // Quiet release of reset with an idle-high clock.
      reset = 1'b1;
      wait_clk(2);
      reset = 1'b0;
      v0 = valid_cycles; f0 = ferr_cycles; b0 = busy_cycles;
      wait_clk(200);
      check_eq("quiet_valid", valid_cycles - v0, 0);
      check_eq("quiet_busy", busy_cycles - b0, 0);
      check_eq("quiet_ferr", ferr_cycles - f0, 0);

      // Randomized frames, random half-periods and inter-frame gaps.
      o0 = overrun_cycles; f0 = ferr_cycles;
      for (int k = 0; k < 24; k++) begin
         byte_v = W'($urandom_range(0, 255));
         half   = $urandom_range(SS + 2, 8);
         gap    = $urandom_range(0, 20);
         exp_q.push_back(byte_v);
         send_bits(byte_v, W, half);
         wait_clk(gap);
      end
      wait_drain("drain_random");
      check_eq("rand_overrun", overrun_cycles - o0, 0);
      check_eq("rand_ferr", ferr_cycles - f0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_spi_receiver
